shift_rotate_engine: RTL and testbench
======================================

# shift_rotate_engine

Parametrised multi-mode shift/rotate engine: the next generation of the team's 8-bit single-step rotator unit. It holds a WIDTH-bit register and moves its contents left or right by a commanded amount. Moves run over multiple cycles, at up to STEP positions per cycle. Supported modes are rotate, logical shift and arithmetic shift. A start/busy/done handshake lets a controller or sequencer issue commands and detect completion.

## Interface
- WIDTH, 8: data register width; ≥ 2.
- AMT_W, 4: width of `amount`; amounts up to 2^AMT_W−1 are legal, including amounts ≥ WIDTH.
- STEP, 1: maximum positions moved per cycle; 1 ≤ STEP ≤ WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- enable  input  1  global qualifier; when 0, all state (data, FSM, counter) holds and `load`/`start` are ignored. `done`, if high, still clears.
- load  input  1  in IDLE with `enable`=1: `data_out` <= `data_in`.
- data_in  input  WIDTH  parallel load value.
- start  input  1  in IDLE with `enable`=1 and `load`=0: accept a command.
- dir  input  1  sampled at accept: 1 = right (toward LSB), 0 = left.
- mode  input  2  sampled at accept: 00 rotate, 01 logical shift (zero fill), 10 arithmetic shift, 11 treated as rotate.
- amount  input  AMT_W  sampled at accept: total positions to move.
- data_out  output  WIDTH  current register contents.
- busy  output  1  high while a command is executing (RUN state).
- done  output  1  one-cycle pulse marking command completion.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- Command capture: latched `dir`/`mode` plus a remaining-count register `rem` (AMT_W bits).
- Priority in IDLE with `enable`=1: `load` > `start`. If both are high, the load executes and the start is dropped (no `busy`, no `done`).
- Accept with `amount`≠0: `rem` <= `amount`, go to RUN. `data_out` is unchanged on the accept edge.
- Accept with `amount`=0: stay in IDLE, `done` <= 1 next edge, `data_out` unchanged.
- Each RUN edge with `enable`=1:
  - k = min(STEP, `rem`).
  - Move `data_out` by k positions per the latched mode/dir.
  - `rem` <= `rem` − k.
  - If `rem` − k = 0: go to IDLE and set `done` <= 1 on the same edge.
- Mode semantics:
  - Rotate: bits wrap end-to-end, in either direction.
  - Logical shift: the vacated end fills with 0.
  - Arithmetic right: the vacated MSBs fill with the current MSB. Arithmetic left is identical to logical left.
- Amounts ≥ WIDTH are executed step by step, with no modulo reduction:
  - Rotate result equals a rotation by `amount` mod WIDTH.
  - Logical result is 0.
  - Arithmetic-right result is all copies of the original MSB.
- In RUN, `start` and `load` are ignored (no queueing). `data_in`, `dir`, `mode` and `amount` may change freely without effect.
- `done` is high for exactly one cycle, then returns to 0 regardless of `enable`. A new `start` may be accepted in the cycle `done` is high.

## Timing
- Reset values: `data_out`=0, `busy`=0, `done`=0, state IDLE, `rem`=0.
- Reset is mid-operation safe: asserting `rst_n`=0 in RUN aborts the command on that edge. No `done` is produced for the aborted command.
- Reset overrides `enable`, `load` and `start`.
- Load latency: `data_out` reflects `data_in` one edge after `load` is sampled.
- Command latency with `enable` held at 1 and N = ceil(`amount`/STEP):
  - Accept at edge E; `busy` high from E.
  - Data steps occur at edges E+1 … E+N.
  - At edge E+N: `busy` falls and `done` rises; `done` falls at E+N+1.
- Zero-amount latency: `done` high for one cycle after the accept edge; `busy` never rises.
- Each cycle with `enable`=0 in RUN extends the latency by one cycle. `busy` stays high throughout.
- Back-to-back: the next command may be accepted at edge E+N+1 at the earliest.

## Test plan
- Rotate left: WIDTH=8, STEP=1, load 0x81, start mode=00 dir=0 amount=3.
  - Required: `data_out` sequence 0x03, 0x06, 0x0C; `busy` high 3 cycles; `done` pulse at E+3; final value 0x0C.
- Shift right variants: load 0x90, right amount=2.
  - mode=10 (arithmetic): 0x90 → 0xC8 → 0xE4.
  - mode=01 (logical): reload 0x90, result 0x24.
- Multi-step rotate right: STEP=2, load 0x01, rotate right amount=5.
  - Required: 3 steps of 2, 2, 1 positions; values 0x40, 0x10, 0x08; `done` at E+3.
- Edge cases, WIDTH=8, STEP=1:
  - amount=0: `done` one cycle, no `busy`, data unchanged.
  - Logical left by amount=9: result 0x00 after 9 steps.
  - Rotate of 0xA5 by amount=8: result 0xA5.
- Enable, start/load interplay and reset abort, all with 0x0F loaded:
  - `enable`=0 for 2 cycles mid-command: `data_out` holds and `done` is delayed by 2 cycles.
  - `start` during RUN: ignored.
  - `load`+`start` together in IDLE: load only, no `busy`.
  - `rst_n`=0 during RUN: `data_out`=0, `busy`=0, no `done`.

Source files
------------

// File: rtl/shift_rotate_engine.sv
// -----------------------------------------------------------------------------
// shift_rotate_engine
//
// Multi-cycle shift/rotate engine. Holds a WIDTH-bit register and moves it left
// or right by a commanded amount, at most STEP positions per clock. Modes are
// rotate, logical shift and arithmetic shift. Amounts >= WIDTH are executed
// step by step, so shifts saturate naturally and rotates wrap.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous, active-low reset
//   enable    global qualifier; 0 freezes data/FSM/counter (done still clears)
//   load      in IDLE: data_out <= data_in (wins over start)
//   data_in   parallel load value
//   start     in IDLE without load: accept a command
//   dir       1 = right (toward LSB), 0 = left; sampled at accept
//   mode      00 rotate, 01 logical, 10 arithmetic, 11 rotate; sampled at accept
//   amount    total positions to move; sampled at accept
//   data_out  register contents
//   busy      high while a command executes
//   done      one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_rotate_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    // The per-cycle move count must hold both the remaining count and STEP,
    // whichever needs more bits.
    localparam int STEP_W = $clog2(STEP + 1);
    localparam int CNT_W  = (AMT_W > STEP_W) ? AMT_W : STEP_W;

    state_t             state;
    state_t             state_next;
    logic [AMT_W-1:0]   rem;
    logic               dir_q;
    logic [1:0]         mode_q;

    logic [CNT_W-1:0]   rem_ext;
    logic [CNT_W-1:0]   k;
    logic [AMT_W-1:0]   rem_after;
    logic [WIDTH-1:0]   moved;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic               accept;

    assign accept = enable && (state == IDLE) && !load && start;

    // k = min(STEP, rem); only meaningful in RUN, where rem is never zero.
    assign rem_ext   = CNT_W'(rem);
    assign k         = (rem_ext < CNT_W'(STEP)) ? rem_ext : CNT_W'(STEP);
    assign rem_after = rem - AMT_W'(k);

    // Barrel move by k. Rotates use a doubled copy of the register so the bits
    // shifted out of one half land in the other.
    // NOTE: every variable driven here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        moved = data_out;
        dbl_l = {data_out, data_out} << k;
        dbl_r = {data_out, data_out} >> k;
        if (dir_q) begin
            if (mode_q == MODE_LSH)
                moved = data_out >> k;
            else if (mode_q == MODE_ASH)
                moved = $unsigned($signed(data_out) >>> k);
            else
                moved = dbl_r[WIDTH-1:0];
        end else begin
            // Arithmetic left is the same as logical left.
            if ((mode_q == MODE_LSH) || (mode_q == MODE_ASH))
                moved = data_out << k;
            else
                moved = dbl_l[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. A zero-amount accept completes without leaving IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && (amount != '0)) state_next = RUN;
            RUN:  if (enable && (rem_after == '0)) state_next = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath, command capture and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            rem      <= '0;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            done     <= 1'b0;
        end else begin
            // done is a single-cycle pulse and clears even when enable is low.
            done <= 1'b0;
            if (enable) begin
                if (state == IDLE) begin
                    if (load) begin
                        data_out <= data_in;
                    end else if (start) begin
                        dir_q  <= dir;
                        mode_q <= mode;
                        rem    <= amount;
                        if (amount == '0)
                            done <= 1'b1;
                    end
                end else begin
                    data_out <= moved;
                    rem      <= rem_after;
                    if (rem_after == '0)
                        done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_rotate_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_rotate_engine
//
// Drives two engines (STEP=1 and STEP=2) from the same inputs and compares both
// against a behavioural model that moves the register one bit at a time.
// Directed sequences pin the model with hand-computed values; a randomized
// phase then exercises enable, load/start interplay and reset.
// -----------------------------------------------------------------------------
module tb_shift_rotate_engine;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             enable  = 1'b0;
    logic             load    = 1'b0;
    logic             start   = 1'b0;
    logic             dir     = 1'b0;
    logic [1:0]       mode    = 2'b00;
    logic [WIDTH-1:0] data_in = '0;
    logic [AMT_W-1:0] amount  = '0;

    logic [WIDTH-1:0] data_out1, data_out2;
    logic             busy1, busy2, done1, done2;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    shift_rotate_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in),
        .start(start), .dir(dir), .mode(mode), .amount(amount),
        .data_out(data_out1), .busy(busy1), .done(done1)
    );

    shift_rotate_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in),
        .start(start), .dir(dir), .mode(mode), .amount(amount),
        .data_out(data_out2), .busy(busy2), .done(done2)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] data;
        bit         busy;
        bit         done;
        int         rem;
        bit         dir;
        bit [1:0]   mode;
    } model_t;

    model_t m1, m2;

    // Move the register by exactly one position.
    function automatic logic [7:0] move1(logic [7:0] d, bit right, bit [1:0] md);
        logic out_bit;
        if (right) begin
            out_bit = d[0];
            d = d >> 1;
            if (md == 2'b01)      d[7] = 1'b0;
            else if (md == 2'b10) d[7] = d[6];   // old MSB now sits in bit 6
            else                  d[7] = out_bit;
        end else begin
            out_bit = d[7];
            d = d << 1;
            d[0] = (md == 2'b00 || md == 2'b11) ? out_bit : 1'b0;
        end
        return d;
    endfunction

    function automatic model_t model_next(model_t s, int step, bit rst_ok, bit en,
                                          bit ld, bit st, bit dr, bit [1:0] md,
                                          int amt, logic [7:0] din);
        model_t n;
        int     k;
        n = s;
        n.done = 1'b0;
        if (!rst_ok) begin
            n = '{default: 0};
            return n;
        end
        if (!en) return n;
        if (!s.busy) begin
            if (ld) begin
                n.data = din;
            end else if (st) begin
                n.dir  = dr;
                n.mode = md;
                if (amt == 0) n.done = 1'b1;
                else begin
                    n.busy = 1'b1;
                    n.rem  = amt;
                end
            end
        end else begin
            k = (s.rem < step) ? s.rem : step;
            for (int i = 0; i < k; i++) n.data = move1(n.data, n.dir, n.mode);
            n.rem = s.rem - k;
            if (n.rem == 0) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 <= model_next(m1, 1, rst_n, enable, load, start, dir, mode, int'(amount), data_in);
        m2 <= model_next(m2, 2, rst_n, enable, load, start, dir, mode, int'(amount), data_in);
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("m1_data", 32'(data_out1), 32'(m1.data));
            check("m1_busy", 32'(busy1), 32'(m1.busy));
            check("m1_done", 32'(done1), 32'(m1.done));
            check("m2_data", 32'(data_out2), 32'(m2.data));
            check("m2_busy", 32'(busy2), 32'(m2.busy));
            check("m2_done", 32'(done2), 32'(m2.done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(logic [7:0] v);
        load    = 1'b1;
        data_in = v;
        tick();
        load = 1'b0;
    endtask

    // Issues a one-edge start; returns just after the accept edge E.
    task automatic cmd(bit d, bit [1:0] md, logic [3:0] amt);
        start  = 1'b1;
        dir    = d;
        mode   = md;
        amount = amt;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy1 || busy2 || done1 || done2) && n < 40) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", 32'(n < 40), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Model sanity pins.
        check("pin_rol",  32'(move1(8'h81, 1'b0, 2'b00)), 32'h03);
        check("pin_asr",  32'(move1(8'h90, 1'b1, 2'b10)), 32'hC8);
        check("pin_lsl",  32'(move1(8'h81, 1'b0, 2'b01)), 32'h02);
        check("pin_ror",  32'(move1(8'h01, 1'b1, 2'b11)), 32'h80);

        tick();
        tick();
        rst_n   = 1'b1;
        started = 1'b1;
        check("reset_data", 32'(data_out1), 32'h00);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_done", 32'(done1), 32'd0);
        enable = 1'b1;

        // Rotate left 0x81 by 3.
        do_load(8'h81);
        check("load_latency", 32'(data_out1), 32'h81);
        cmd(1'b0, 2'b00, 4'd3);
        check("rol_accept_busy", 32'(busy1), 32'd1);
        check("rol_accept_data", 32'(data_out1), 32'h81);
        tick(); check("rol_s1", 32'(data_out1), 32'h03);
        tick(); check("rol_s2", 32'(data_out1), 32'h06);
        tick(); check("rol_s3", 32'(data_out1), 32'h0C);
        check("rol_done", 32'(done1), 32'd1);
        check("rol_busy_fall", 32'(busy1), 32'd0);
        tick(); check("rol_done_fall", 32'(done1), 32'd0);
        wait_idle();

        // Arithmetic and logical right of 0x90 by 2.
        do_load(8'h90);
        cmd(1'b1, 2'b10, 4'd2);
        tick(); check("asr_s1", 32'(data_out1), 32'hC8);
        tick(); check("asr_s2", 32'(data_out1), 32'hE4);
        wait_idle();
        do_load(8'h90);
        cmd(1'b1, 2'b01, 4'd2);
        wait_idle();
        check("lsr_result", 32'(data_out1), 32'h24);

        // STEP=2 rotate right 0x01 by 5: steps of 2, 2, 1.
        do_load(8'h01);
        cmd(1'b1, 2'b00, 4'd5);
        tick(); check("step2_s1", 32'(data_out2), 32'h40);
        tick(); check("step2_s2", 32'(data_out2), 32'h10);
        tick(); check("step2_s3", 32'(data_out2), 32'h08);
        check("step2_done", 32'(done2), 32'd1);
        wait_idle();
        check("step1_ror5", 32'(data_out1), 32'h08);

        // Zero amount.
        do_load(8'h5A);
        cmd(1'b0, 2'b00, 4'd0);
        check("zero_busy", 32'(busy1), 32'd0);
        check("zero_done", 32'(done1), 32'd1);
        check("zero_data", 32'(data_out1), 32'h5A);
        tick(); check("zero_done_fall", 32'(done1), 32'd0);

        // Logical left by 9 clears; rotate by 8 is identity.
        do_load(8'hFF);
        cmd(1'b0, 2'b01, 4'd9);
        wait_idle();
        check("lsl9_d1", 32'(data_out1), 32'h00);
        check("lsl9_d2", 32'(data_out2), 32'h00);
        do_load(8'hA5);
        cmd(1'b1, 2'b00, 4'd8);
        wait_idle();
        check("rot8_d1", 32'(data_out1), 32'hA5);
        check("rot8_d2", 32'(data_out2), 32'hA5);

        // Enable low for two cycles mid-command.
        do_load(8'h0F);
        cmd(1'b0, 2'b00, 4'd3);
        tick(); check("en_s1", 32'(data_out1), 32'h1E);
        enable = 1'b0;
        tick(); check("en_hold1", 32'(data_out1), 32'h1E);
        check("en_hold_busy", 32'(busy1), 32'd1);
        tick(); check("en_hold2", 32'(data_out1), 32'h1E);
        check("en_no_done", 32'(done1), 32'd0);
        enable = 1'b1;
        tick(); check("en_s2", 32'(data_out1), 32'h3C);
        tick(); check("en_s3", 32'(data_out1), 32'h78);
        check("en_done_late", 32'(done1), 32'd1);
        wait_idle();

        // Start during RUN is ignored.
        do_load(8'h0F);
        cmd(1'b0, 2'b00, 4'd3);
        start = 1'b1; mode = 2'b01; amount = 4'd5;
        tick(); start = 1'b0;
        check("run_start_s1", 32'(data_out1), 32'h1E);
        tick(); tick();
        check("run_start_done", 32'(done1), 32'd1);
        check("run_start_data", 32'(data_out1), 32'h78);
        tick(); check("run_start_no_requeue", 32'(busy1), 32'd0);
        wait_idle();

        // Load and start together: load only.
        load = 1'b1; start = 1'b1; data_in = 8'h3C; amount = 4'd2;
        tick();
        load = 1'b0; start = 1'b0;
        check("ldst_data", 32'(data_out1), 32'h3C);
        check("ldst_busy", 32'(busy1), 32'd0);
        tick(); check("ldst_no_done", 32'(done1), 32'd0);

        // Reset aborts a running command.
        do_load(8'h0F);
        cmd(1'b0, 2'b00, 4'd5);
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_data", 32'(data_out1), 32'h00);
        check("abort_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        tick(); check("abort_no_done", 32'(done1), 32'd0);
        check("abort_no_done2", 32'(done2), 32'd0);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 63) != 0);
            enable  = ($urandom_range(0, 7) != 0);
            load    = ($urandom_range(0, 9) == 0);
            start   = ($urandom_range(0, 2) == 0);
            dir     = 1'($urandom);
            mode    = 2'($urandom);
            amount  = 4'($urandom);
            data_in = 8'($urandom);
            tick();
        end
        rst_n = 1'b1; enable = 1'b1; load = 1'b0; start = 1'b0;
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
